div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M divide group (DIV, DIVU, REM, REMU), sitting beside the single-cycle ALU in the execute stage. The ALU returns its result combinationally in the same cycle; this block is its multi-cycle counterpart. It accepts an operand pair through a start/busy/done handshake and produces one quotient or remainder bit per cycle using restoring division. Divide-by-zero and signed overflow are detected at issue and complete in one cycle.

---
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for the RV32M divide group (DIV, DIVU, REM, REMU).
// One quotient bit per cycle; divide-by-zero and signed overflow finish at issue.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic             overflow_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] dvd_q,      dvd_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             is_rem_q,   is_rem_d;
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    // Issue-side operand conditioning: signed ops divide magnitudes, fix signs at the end.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign signed_op = ~op_i[0];
    assign a_neg     = signed_op & A_i[WIDTH-1];
    assign b_neg     = signed_op & B_i[WIDTH-1];
    assign a_mag     = a_neg ? -A_i : A_i;
    assign b_mag     = b_neg ? -B_i : B_i;

    // One restoring step; the compare is WIDTH+1 bits, but the difference always fits WIDTH.
    logic [WIDTH:0]   shift_r;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    assign shift_r  = {rem_q, dvd_q[WIDTH-1]};
    assign ge       = shift_r >= {1'b0, dvs_q};
    assign rem_sub  = shift_r[WIDTH-1:0] - dvs_q;
    assign quo_next = {dvd_q[WIDTH-2:0], ge};
    assign rem_next = ge ? rem_sub : shift_r[WIDTH-1:0];

    always_comb begin
        // NOTE: every signal defaults to its held value first so no path infers a latch.
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        is_rem_d   = is_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    if (B_i == '0) begin
                        state_d    = S_DONE;
                        result_d   = op_i[1] ? A_i : '1;
                        div_zero_d = 1'b1;
                        overflow_d = 1'b0;
                    end else if (signed_op && A_i == MIN_NEG && B_i == '1) begin
                        state_d    = S_DONE;
                        result_d   = op_i[1] ? '0 : MIN_NEG;
                        div_zero_d = 1'b0;
                        overflow_d = 1'b1;
                    end else begin
                        state_d   = S_CALC;
                        dvd_d     = a_mag;
                        dvs_d     = b_mag;
                        rem_d     = '0;
                        cnt_d     = CW'(WIDTH);
                        is_rem_d  = op_i[1];
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            S_CALC: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = S_DONE;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    if (is_rem_q) result_d = neg_rem_q ? -rem_next : rem_next;
                    else          result_d = neg_quo_q ? -quo_next : quo_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            is_rem_q   <= is_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign result_o   = result_q;
    assign busy_o     = (state_q == S_CALC);
    assign done_o     = (state_q == S_DONE);
    assign div_zero_o = div_zero_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, special cases, ignored start and reset abort.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] A_i = '0;
    logic [31:0] B_i = '0;
    logic [31:0] result_o;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .A_i        (A_i),
        .B_i        (B_i),
        .result_o   (result_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request so it is sampled at the next rising edge; returns #1 after that edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        A_i     = a;
        B_i     = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Count post-edge samples until done_o, bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(input int start_n, output int lat, output int busy_cnt);
        lat      = start_n;
        busy_cnt = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input logic exp_dz, input logic exp_ov);
        int          lat;
        int          bc;
        logic [31:0] prev;
        prev = result_o;
        issue(op, a, b);
        if (exp_lat > 1) check({tag, "_hold"}, result_o, prev);
        wait_done(1, lat, bc);
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bc),  32'(exp_lat - 1));
        check({tag, "_res"},  result_o, exp_res);
        check({tag, "_dz"},   {31'b0, div_zero_o}, {31'b0, exp_dz});
        check({tag, "_ov"},   {31'b0, overflow_o}, {31'b0, exp_ov});
        @(posedge clk_i); #1;
        check({tag, "_pulse"}, {31'b0, done_o}, 32'd0);
        check({tag, "_keep"},  result_o, exp_res);
    endtask

    initial begin
        int lat;
        int bc;
        int dones;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_res",  result_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_dz",   {31'b0, div_zero_o}, 32'd0);
        check("rst_ov",   {31'b0, overflow_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33, 1'b0, 1'b0);
        run_op("remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33, 1'b0, 1'b0);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1'b0, 1'b0);
        run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1'b0, 1'b0);
        run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 1'b0, 1'b0);
        run_op("div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, 1'b0, 1'b0);
        run_op("divu_big",     OP_DIVU, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  33, 1'b0, 1'b0);
        run_op("divu_5_0",     OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b1, 1'b0);
        run_op("remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'd5,          1,  1'b1, 1'b0);
        run_op("rem_m5_0",     OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  1'b1, 1'b0);
        run_op("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0, 1'b1);
        run_op("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1'b0, 1'b1);
        run_op("divu_min_m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 1'b0, 1'b0);
        run_op("div_min_2",    OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33, 1'b0, 1'b0);

        // A start during CALC must be dropped; the original op completes on time.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        repeat (8) begin @(posedge clk_i); #1; end
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(10, lat, bc);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_res", result_o, 32'hFFFF_FFFF);

        // Back-to-back: issue in the DONE cycle, CALC follows immediately.
        issue(OP_DIVU, 32'd9, 32'd3);
        check("b2b_busy", {31'b0, busy_o}, 32'd1);
        check("b2b_hold", result_o, 32'hFFFF_FFFF);
        wait_done(1, lat, bc);
        check("b2b_lat", 32'(lat), 32'd33);
        check("b2b_res", result_o, 32'd3);

        // Reset mid-CALC aborts without a done pulse.
        @(posedge clk_i); #1;
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (14) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("abort_res",  result_o, 32'd0);
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        check("abort_done", {31'b0, done_o}, 32'd0);
        check("abort_dz",   {31'b0, div_zero_o}, 32'd0);
        check("abort_ov",   {31'b0, overflow_o}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) dones++;
        end
        check("abort_quiet", 32'(dones), 32'd0);

        run_op("divu_1000_10", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
